// File: rtl/mul_issue_arbiter_pkg.sv
// mul_issue_arbiter_pkg: shared types for the multiply issue arbiter.
package mul_issue_arbiter_pkg;
  localparam int MUL_TAG_W = 6;
  localparam int MUL_XLEN  = 32;
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_HOLD, MUL_DRAIN} mul_unit_state_t;
  typedef struct packed {
    logic [MUL_TAG_W-1:0] tag;
    logic [MUL_XLEN-1:0]  data;
  } mul_hold_t;
  function automatic int next_idx(int i, int n);
    return (i + 1) % n;
  endfunction
endpackage

// File: rtl/mul_issue_arbiter_if.sv
// mul_issue_arbiter_if: requester, functional-unit and writeback signals of the multiply issue arbiter.
interface mul_issue_arbiter_if
  import mul_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_MUL = 2,
  parameter int TAG_W   = MUL_TAG_W,
  parameter int XLEN    = MUL_XLEN
);
  logic                    flush;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]      req_grant;
  logic [NUM_MUL-1:0]      fu_ready;
  logic [NUM_MUL-1:0]      fu_start;
  logic [NUM_MUL-1:0]      fu_done;
  logic [NUM_MUL*XLEN-1:0] fu_result;
  logic                    wb_valid;
  logic [TAG_W-1:0]        wb_tag;
  logic [XLEN-1:0]         wb_data;
  logic                    wb_ready;
  logic                    err_spurious;
  modport master (
    output flush, req_valid, req_tag, fu_ready, fu_done, fu_result, wb_ready,
    input  req_grant, fu_start, wb_valid, wb_tag, wb_data, err_spurious
  );
  modport slave (
    input  flush, req_valid, req_tag, fu_ready, fu_done, fu_result, wb_ready,
    output req_grant, fu_start, wb_valid, wb_tag, wb_data, err_spurious
  );
endinterface

// File: rtl/mul_issue_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from ptr with wraparound.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] c;
  logic          found;
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = PW'((int'(ptr) + k) % N);
      if (!found && req[c]) begin
        gnt[c] = 1'b1;
        idx = c;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter: issues multiplies to shared units, captures their results
// and drains them to the writeback bus.
module mul_issue_arbiter
  import mul_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_MUL = 2,
  parameter int TAG_W   = MUL_TAG_W,
  parameter int XLEN    = MUL_XLEN
) (
  input logic                clk,
  input logic                rst,
  mul_issue_arbiter_if.slave bus
);
  localparam int RPW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int MPW = NUM_MUL > 1 ? $clog2(NUM_MUL) : 1;
  mul_unit_state_t    st_q [NUM_MUL];
  mul_unit_state_t    st_d [NUM_MUL];
  mul_hold_t          hold_q [NUM_MUL];
  mul_hold_t          hold_d [NUM_MUL];
  logic [RPW-1:0]     issue_ptr_q, issue_ptr_d, win_idx;
  logic [MPW-1:0]     wb_ptr_q, wb_ptr_d, wb_arb_idx, wb_sel, lock_idx_q, lock_idx_d;
  logic [NUM_REQ-1:0] win_gnt;
  logic [NUM_MUL-1:0] free, held, tgt_oh, wb_gnt;
  logic [TAG_W-1:0]   win_tag;
  logic               lock_q, lock_d, err_q, err_d, issue_ok, wb_fire;

  rr_arbiter #(.N(NUM_REQ)) u_issue_rr (.req(bus.req_valid), .ptr(issue_ptr_q), .gnt(win_gnt), .idx(win_idx));
  rr_arbiter #(.N(NUM_MUL)) u_wb_rr (.req(held), .ptr(wb_ptr_q), .gnt(wb_gnt), .idx(wb_arb_idx));

  always_comb begin
    for (int j = 0; j < NUM_MUL; j++) begin
      free[j] = st_q[j] == MUL_IDLE && bus.fu_ready[j];
      held[j] = st_q[j] == MUL_HOLD;
    end
  end

  // A stalled writeback keeps presenting the same unit even if a higher-priority unit fills meanwhile
  always_comb begin
    tgt_oh = free & (~free + NUM_MUL'(1));
    issue_ok = rst && !bus.flush && |free && |bus.req_valid;
    win_tag = bus.req_tag[win_idx*TAG_W +: TAG_W];
    wb_sel = lock_q ? lock_idx_q : wb_arb_idx;
    wb_fire = bus.wb_valid && bus.wb_ready;
    issue_ptr_d = issue_ok ? RPW'(next_idx(int'(win_idx), NUM_REQ)) : issue_ptr_q;
    wb_ptr_d = wb_fire ? MPW'(next_idx(int'(wb_sel), NUM_MUL)) : wb_ptr_q;
    lock_d = bus.wb_valid && !bus.wb_ready;
    lock_idx_d = wb_sel;
  end

  assign bus.req_grant    = issue_ok ? win_gnt : '0;
  assign bus.fu_start     = issue_ok ? tgt_oh : '0;
  assign bus.wb_valid     = rst && !bus.flush && |held;
  assign bus.wb_tag       = bus.wb_valid ? hold_q[wb_sel].tag : '0;
  assign bus.wb_data      = bus.wb_valid ? hold_q[wb_sel].data : '0;
  assign bus.err_spurious = err_q;

  always_comb begin
    err_d = err_q;
    for (int j = 0; j < NUM_MUL; j++) begin
      st_d[j] = st_q[j];
      hold_d[j] = hold_q[j];
      if (bus.fu_done[j] && (st_q[j] == MUL_IDLE || st_q[j] == MUL_HOLD)) err_d = 1'b1;
      case (st_q[j])
        MUL_IDLE: if (issue_ok && tgt_oh[j]) begin
          st_d[j] = MUL_BUSY;
          hold_d[j].tag = win_tag;
        end
        MUL_BUSY: if (bus.flush) st_d[j] = bus.fu_done[j] ? MUL_IDLE : MUL_DRAIN;
          else if (bus.fu_done[j]) begin
            st_d[j] = MUL_HOLD;
            hold_d[j].data = bus.fu_result[j*XLEN +: XLEN];
          end
        MUL_HOLD: if (bus.flush || (wb_fire && (lock_q ? lock_idx_q == MPW'(j) : wb_gnt[j]))) st_d[j] = MUL_IDLE;
        default: if (bus.fu_done[j]) st_d[j] = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NUM_MUL; j++) begin
        st_q[j] <= MUL_IDLE;
        hold_q[j] <= '0;
      end
      issue_ptr_q <= '0;
      wb_ptr_q <= '0;
      lock_q <= 1'b0;
      lock_idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      hold_q <= hold_d;
      issue_ptr_q <= issue_ptr_d;
      wb_ptr_q <= wb_ptr_d;
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q <= err_d;
    end
  end
endmodule
